// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, assembles 11-bit frames,
// decodes E0/F0 prefixes into {ext, brk, code} events and queues them in a 4-deep FWFT FIFO.
module ps2_kbd_ctrl #(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic       ev_valid,
    output logic [9:0] ev_data,
    output logic       ovf,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic [2:0]    sync_r;
    logic [1:0]    dsync_r;
    logic          fall_s;
    logic          bit_s;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic [TW-1:0] tmo_r;
    logic [7:0]    code_r;
    logic          code_stb_r;
    logic          frame_err_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic          push_s;
    logic [9:0]    push_data_s;

    logic [9:0]    mem_r [0:3];
    logic [1:0]    wr_ptr_r;
    logic [1:0]    rd_ptr_r;
    logic [2:0]    cnt_r;
    logic [2:0]    cnt_nxt_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic          full_s;
    logic          ovf_set_s;
    logic [9:0]    head_nxt_s;

    // Data takes two stages so it stays aligned with sync_r[1], the newer edge-detect tap.
    assign fall_s    = sync_r[2] & ~sync_r[1];
    assign bit_s     = dsync_r[1];
    assign frame_err = frame_err_r;

    // Line synchronisers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= 3'b111;
            dsync_r <= 2'b11;
        end else begin
            sync_r  <= {sync_r[1:0], ps2_clk};
            dsync_r <= {dsync_r[0], ps2_data};
        end
    end

    // Frame assembly, validation and inter-edge timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= 4'd0;
            shift_r     <= 10'd0;
            tmo_r       <= '0;
            code_r      <= 8'd0;
            code_stb_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            code_stb_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (fall_s) begin
                tmo_r <= '0;
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    if (!shift_r[0] && bit_s && odd_parity_ok(shift_r[9:1])) begin
                        code_r     <= shift_r[8:1];
                        code_stb_r <= 1'b1;
                    end else begin
                        frame_err_r <= 1'b1;
                    end
                end else begin
                    shift_r[bit_cnt_r] <= bit_s;
                    bit_cnt_r          <= bit_cnt_r + 4'd1;
                end
            end else if (bit_cnt_r != 4'd0) begin
                if (tmo_r == TMO_LAST) begin
                    bit_cnt_r   <= 4'd0;
                    tmo_r       <= '0;
                    frame_err_r <= 1'b1;
                end else begin
                    tmo_r <= tmo_r + 1'b1;
                end
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

    // Prefix decode: next state and the event to push for the accepted code.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        push_data_s = 10'd0;
        if (code_stb_r) begin
            case (state_r)
                IDLE: begin
                    if (code_r == 8'hE0) begin
                        state_nxt_s = EXT;
                    end else if (code_r == 8'hF0) begin
                        state_nxt_s = BRK;
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = {2'b00, code_r};
                    end
                end
                EXT: begin
                    if (code_r == 8'hF0) begin
                        state_nxt_s = EXT_BRK;
                    end else if (code_r == 8'hE0) begin
                        state_nxt_s = EXT;
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = {2'b10, code_r};
                        state_nxt_s = IDLE;
                    end
                end
                BRK: begin
                    if (code_r == 8'hE0) begin
                        state_nxt_s = EXT_BRK;
                    end else begin
                        push_s      = 1'b1;
                        push_data_s = {2'b01, code_r};
                        state_nxt_s = IDLE;
                    end
                end
                EXT_BRK: begin
                    push_s      = 1'b1;
                    push_data_s = {2'b11, code_r};
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else if (frame_err_r) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Decode state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO control and the next head value, so ev_data can be a plain register.
    always_comb begin
        full_s     = (cnt_r == 3'd4);
        do_pop_s   = rd_en && (cnt_r != 3'd0);
        do_push_s  = push_s && (!full_s || do_pop_s);
        ovf_set_s  = push_s && full_s && !do_pop_s;
        cnt_nxt_s  = cnt_r + {2'b00, do_push_s} - {2'b00, do_pop_s};
        head_nxt_s = ev_data;
        if (cnt_nxt_s == 3'd0) begin
            head_nxt_s = 10'd0;
        end else if (do_pop_s) begin
            if (cnt_r == 3'd1) begin
                head_nxt_s = push_data_s;
            end else begin
                head_nxt_s = mem_r[rd_ptr_r + 2'd1];
            end
        end else if (cnt_r == 3'd0) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = ev_data;
        end
    end

    // Event FIFO storage, pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 10'd0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            cnt_r    <= 3'd0;
            ev_valid <= 1'b0;
            ev_data  <= 10'd0;
            ovf      <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            cnt_r    <= cnt_nxt_s;
            ev_valid <= (cnt_nxt_s != 3'd0);
            ev_data  <= head_nxt_s;
            if (ovf_set_s) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: bit-banged PS/2 frames with hand-computed expected events.
module tb_ps2_kbd_ctrl;

    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       err_clr;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ovf;
    logic       frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_pulses = 0;

    ps2_kbd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .err_clr(err_clr), .ev_valid(ev_valid),
        .ev_data(ev_data), .ovf(ovf), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) err_pulses <= err_pulses + 1;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Start, data LSB first and parity; leaves the stop bit to the caller.
    task automatic send_head(input logic [7:0] code, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(~(^code) ^ flip);
    endtask

    // Stop bit; optionally raises rd_en exactly in the push cycle (E+1).
    task automatic send_frame(input logic [7:0] code, input logic flip, input logic rd_at_push);
        send_head(code, flip);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        if (rd_at_push) rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (HALF - 4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL reset_ev_valid: got %b want 0", ev_valid); else pass_cnt++;
        total_cnt++; if (ev_data !== 10'h000) $display("FAIL reset_ev_data: got %h want 000", ev_data); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_make();
        send_head(8'h1C, 1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL single_early: ev_valid got %b want 0", ev_valid); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (ev_valid !== 1'b1) $display("FAIL single_latency: ev_valid got %b want 1", ev_valid); else pass_cnt++;
        total_cnt++; if (ev_data !== 10'h01C) $display("FAIL single_data: got %h want 01C", ev_data); else pass_cnt++;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL single_pop: ev_valid got %b want 0", ev_valid); else pass_cnt++;
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        total_cnt++; if (ev_valid !== 1'b1) $display("FAIL extbrk_valid: got %b want 1", ev_valid); else pass_cnt++;
        total_cnt++; if (ev_data !== 10'h375) $display("FAIL extbrk_data: got %h want 375", ev_data); else pass_cnt++;
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL extbrk_single: ev_valid got %b want 0", ev_valid); else pass_cnt++;
        send_frame(8'h1C, 1'b0, 1'b0);
        total_cnt++; if (ev_data !== 10'h01C) $display("FAIL extbrk_idle_after: got %h want 01C", ev_data); else pass_cnt++;
        pop();
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b0);
        total_cnt++; if (err_pulses - e0 !== 1) $display("FAIL parity_err_pulses: got %0d want 1", err_pulses - e0); else pass_cnt++;
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL parity_no_push: ev_valid got %b want 0", ev_valid); else pass_cnt++;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        total_cnt++; if (ev_data !== 10'h11C) $display("FAIL parity_recover: got %h want 11C", ev_data); else pass_cnt++;
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL parity_recover_pop: ev_valid got %b want 0", ev_valid); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [7:0] codes [0:4];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 4; i++) send_frame(codes[i], 1'b0, 1'b0);
        total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_at_full: got %b want 0", ovf); else pass_cnt++;
        send_frame(codes[4], 1'b0, 1'b0);
        total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (ev_valid !== 1'b1 || ev_data !== {2'b00, codes[i]})
                $display("FAIL ovf_pop%0d: got v=%b %h want v=1 %h", i, ev_valid, ev_data, {2'b00, codes[i]});
            else pass_cnt++;
            pop();
        end
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL ovf_drained: ev_valid got %b want 0", ev_valid); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else pass_cnt++;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [0:3];
        exp = '{8'h1D, 8'h24, 8'h2D, 8'h2C};
        send_frame(8'h15, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        send_frame(8'h2C, 1'b0, 1'b1);
        total_cnt++; if (ovf !== 1'b0) $display("FAIL full_pushpop_ovf: got %b want 0", ovf); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (ev_valid !== 1'b1 || ev_data !== {2'b00, exp[i]})
                $display("FAIL full_pushpop%0d: got v=%b %h want v=1 %h", i, ev_valid, ev_data, {2'b00, exp[i]});
            else pass_cnt++;
            pop();
        end
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL full_pushpop_empty: ev_valid got %b want 0", ev_valid); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_pulses;
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        repeat (TMO + 60) @(negedge clk);
        total_cnt++; if (err_pulses - e0 !== 1) $display("FAIL timeout_pulses: got %0d want 1", err_pulses - e0); else pass_cnt++;
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL timeout_no_push: ev_valid got %b want 0", ev_valid); else pass_cnt++;
        send_frame(8'h1C, 1'b0, 1'b0);
        total_cnt++; if (ev_data !== 10'h01C) $display("FAIL timeout_recover: got %h want 01C", ev_data); else pass_cnt++;
        pop();
    endtask

    task automatic test_reset_midframe();
        int e0;
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk); rst = 1'b0;
        e0 = err_pulses;
        pop();
        send_frame(8'h2C, 1'b0, 1'b0);
        total_cnt++; if (ev_data !== 10'h02C) $display("FAIL rst_mid_data: got %h want 02C", ev_data); else pass_cnt++;
        total_cnt++; if (err_pulses - e0 !== 0) $display("FAIL rst_mid_err: got %0d want 0", err_pulses - e0); else pass_cnt++;
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL rst_mid_pop: ev_valid got %b want 0", ev_valid); else pass_cnt++;
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        err_clr  = 1'b0;
        test_reset();
        test_single_make();
        test_ext_break();
        test_parity_err();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
